// File: rtl/multi_cycle_control_pkg.sv
// Shared LEGv8 multi-cycle control definitions: state codes, opcode constants,
// datapath select encodings and the per-state Moore control decode.
package multi_cycle_control_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_RWB    = 4'd7,
      ST_CBZ    = 4'd8,
      ST_BR     = 4'd9,
      ST_HALT   = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      CLS_LOAD    = 3'd0,
      CLS_STORE   = 3'd1,
      CLS_RTYPE   = 3'd2,
      CLS_CBZ     = 3'd3,
      CLS_B       = 3'd4,
      CLS_ILLEGAL = 3'd5
   } op_class_t;

   localparam logic [10:0] OPC_LDUR    = 11'b11111000010;
   localparam logic [10:0] OPC_STUR    = 11'b11111000000;
   localparam logic [10:0] OPC_ADD     = 11'b10001011000;
   localparam logic [10:0] OPC_SUB     = 11'b11001011000;
   localparam logic [10:0] OPC_AND     = 11'b10001010000;
   localparam logic [10:0] OPC_ORR     = 11'b10101010000;
   localparam logic [7:0]  OPC_CBZ_PFX = 8'b10110100;
   localparam logic [5:0]  OPC_B_PFX   = 6'b000101;

   localparam logic [1:0] SIGNOP_D  = 2'b00;
   localparam logic [1:0] SIGNOP_B  = 2'b01;
   localparam logic [1:0] SIGNOP_CB = 2'b10;

   localparam logic [1:0] ALUSRCB_REG   = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMX4 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   // The *_ready / *_zero bits mark enables that are further qualified by
   // MemReady or Zero in the same cycle; everything else is pure Moore.
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       reg2loc;
      logic       pc_src;
      logic       pc_wr_always;
      logic       pc_wr_zero;
      logic       pc_wr_ready;
      logic       ir_wr_ready;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] sign_op;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.mem_read    = 1'b1;
            c.alu_src_b   = ALUSRCB_FOUR;
            c.pc_wr_ready = 1'b1;
            c.ir_wr_ready = 1'b1;
         end
         ST_MEMADR: begin
            c.sign_op   = SIGNOP_D;
            c.alu_src_b = ALUSRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         ST_MEMRD: c.mem_read = 1'b1;
         ST_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            c.mem_write = 1'b1;
            c.reg2loc   = 1'b1;
         end
         ST_EXEC: begin
            c.alu_src_b = ALUSRCB_REG;
            c.alu_op    = ALUOP_RTYPE;
         end
         ST_RWB: c.reg_write = 1'b1;
         ST_CBZ: begin
            c.sign_op    = SIGNOP_CB;
            c.reg2loc    = 1'b1;
            c.alu_op     = ALUOP_PASSB;
            c.pc_src     = 1'b1;
            c.pc_wr_zero = 1'b1;
         end
         ST_BR: begin
            c.sign_op      = SIGNOP_B;
            c.alu_src_b    = ALUSRCB_IMMX4;
            c.pc_wr_always = 1'b1;
            c.pc_src       = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath/memory signal bundle; master is the control unit.
interface multi_cycle_control_if;
   logic [10:0] Opcode;
   logic        Zero;
   logic        MemReady;
   logic        PCWrite;
   logic        IRWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUOp;
   logic [1:0]  SignOp;
   logic        Reg2Loc;
   logic        MemtoReg;
   logic        PCSrc;
   logic [3:0]  State;
   logic        Fault;

   modport master (
      input  Opcode, Zero, MemReady,
      output PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
             ALUSrcB, ALUOp, SignOp, Reg2Loc, MemtoReg, PCSrc, State, Fault
   );

   modport slave (
      output Opcode, Zero, MemReady,
      input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
             ALUSrcB, ALUOp, SignOp, Reg2Loc, MemtoReg, PCSrc, State, Fault
   );
endinterface

// File: rtl/multi_cycle_control_opcode_class.sv
// Combinational LEGv8 opcode classifier: Inst[31:21] -> instruction class.
module opcode_class
   import multi_cycle_control_pkg::*;
(
   input  logic [10:0] opcode,
   output op_class_t   op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      if (opcode == OPC_LDUR) begin
         op_class = CLS_LOAD;
      end else if (opcode == OPC_STUR) begin
         op_class = CLS_STORE;
      end else if (opcode == OPC_ADD || opcode == OPC_SUB ||
                   opcode == OPC_AND || opcode == OPC_ORR) begin
         op_class = CLS_RTYPE;
      end else if (opcode[10:3] == OPC_CBZ_PFX) begin
         op_class = CLS_CBZ;
      end else if (opcode[10:5] == OPC_B_PFX) begin
         op_class = CLS_B;
      end
   end

endmodule

// File: rtl/multi_cycle_control.sv
// LEGv8 multi-cycle control unit with memory wait-limit watchdog and sticky
// fault; HALT is absorbing until Reset.
module multi_cycle_control
   import multi_cycle_control_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic                  CLK,
   input  logic                  Reset,
   multi_cycle_control_if.master bus
);

   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fault_q, fault_d;
   logic              is_load_q, is_load_d;
   logic              rst_dly_q;
   ctrl_t             ctrl_q, ctrl_d;
   op_class_t         op_class;
   logic              mem_wait;
   logic              en_block;

   opcode_class u_opcode_class (
      .opcode   (bus.Opcode),
      .op_class (op_class)
   );

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      fault_d   = fault_q;
      is_load_d = is_load_q;
      // The first FETCH cycle after reset is a bubble: no write enables are
      // allowed, so the fetch is not accepted and no wait cycle is counted.
      mem_wait  = !rst_dly_q &&
                  (state_q == ST_FETCH || state_q == ST_MEMRD || state_q == ST_MEMWR);
      if (mem_wait) begin
         if (bus.MemReady) begin
            wait_d = '0;
            case (state_q)
               ST_FETCH: state_d = ST_DECODE;
               ST_MEMRD: state_d = ST_MEMWB;
               default:  state_d = ST_FETCH;
            endcase
         end else if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            fault_d = 1'b1;
            state_d = ST_HALT;
         end else begin
            wait_d = wait_q + WAIT_W'(1);
         end
      end else begin
         case (state_q)
            ST_DECODE: begin
               case (op_class)
                  CLS_LOAD: begin
                     state_d   = ST_MEMADR;
                     is_load_d = 1'b1;
                  end
                  CLS_STORE: begin
                     state_d   = ST_MEMADR;
                     is_load_d = 1'b0;
                  end
                  CLS_RTYPE: state_d = ST_EXEC;
                  CLS_CBZ:   state_d = ST_CBZ;
                  CLS_B:     state_d = ST_BR;
                  default: begin
                     state_d = ST_HALT;
                     fault_d = 1'b1;
                  end
               endcase
            end
            ST_MEMADR: state_d = is_load_q ? ST_MEMRD : ST_MEMWR;
            ST_EXEC:   state_d = ST_RWB;
            ST_MEMWB, ST_RWB, ST_CBZ, ST_BR: state_d = ST_FETCH;
            ST_FETCH, ST_MEMRD, ST_MEMWR, ST_HALT: state_d = state_q;
            default: begin
               state_d = ST_HALT;
               fault_d = 1'b1;
            end
         endcase
      end
      ctrl_d = decode_ctrl(state_d);
   end

   always_ff @(posedge CLK) begin
      rst_dly_q <= Reset;
      if (Reset) begin
         state_q   <= ST_FETCH;
         wait_q    <= '0;
         fault_q   <= 1'b0;
         is_load_q <= 1'b0;
         ctrl_q    <= decode_ctrl(ST_FETCH);
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         fault_q   <= fault_d;
         is_load_q <= is_load_d;
         ctrl_q    <= ctrl_d;
      end
   end

   // Architectural write enables are held off while Reset is high and for
   // one cycle afterwards.
   assign en_block = Reset | rst_dly_q;

   assign bus.PCWrite  = !en_block && (ctrl_q.pc_wr_always ||
                                       (ctrl_q.pc_wr_ready && bus.MemReady) ||
                                       (ctrl_q.pc_wr_zero && bus.Zero));
   assign bus.IRWrite  = !en_block && ctrl_q.ir_wr_ready && bus.MemReady;
   assign bus.RegWrite = !en_block && ctrl_q.reg_write;
   assign bus.MemWrite = !en_block && ctrl_q.mem_write;
   assign bus.MemRead  = ctrl_q.mem_read;
   assign bus.ALUSrcB  = ctrl_q.alu_src_b;
   assign bus.ALUOp    = ctrl_q.alu_op;
   assign bus.SignOp   = ctrl_q.sign_op;
   assign bus.Reg2Loc  = ctrl_q.reg2loc;
   assign bus.MemtoReg = ctrl_q.mem_to_reg;
   assign bus.PCSrc    = ctrl_q.pc_src;
   assign bus.State    = state_q;
   assign bus.Fault    = fault_q;

endmodule
